// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, flag indices, FSM states and format helpers for fpu_multicycle
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV_ITER,
    S_DIV_NORM,
    S_DONE
  } fpu_state_t;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Encodings are returned in a wide word; callers slice to their own width.
  function automatic logic [63:0] fpu_inf(input int exp_w, input int man_w);
    return ((64'(1) << exp_w) - 64'(1)) << man_w;
  endfunction

  function automatic logic [63:0] fpu_qnan(input int exp_w, input int man_w);
    return fpu_inf(exp_w, man_w) | (64'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_multicycle_if.sv
// rtl/fpu_multicycle_if.sv - operand/result handshake bundle for fpu_multicycle
interface fpu_multicycle_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - normalise, round-to-nearest-even, range check and pack one result
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+2:0]  exp_in,
  input  logic [MAN_W+4:0]         mag,
  output logic [EXP_W+MAN_W:0]     res,
  output logic [3:0]               flg
);
  localparam int MW = MAN_W + 5;
  localparam int XW = EXP_W + 3;
  localparam logic signed [XW-1:0] ONE_S  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_S = '0;
  localparam logic signed [XW-1:0] EMAX_S = XW'((1 << EXP_W) - 1);

  logic [MW-2:0]          m1, m2;
  logic signed [XW-1:0]   e1, e2, e3;
  logic [MAN_W:0]         sum;
  logic                   up;
  int                     lz;

  always_comb begin
    res = '0;
    flg = '0;
    m1  = mag[MW-2:0];
    e1  = exp_in;
    // mag is {carry, hidden, fraction, guard, round, sticky}
    if (mag[MW-1]) begin
      m1 = mag[MW-1:1] | (MW-1)'(mag[0]);
      e1 = exp_in + ONE_S;
    end
    lz = 0;
    for (int i = 0; i < MW - 1; i++) begin
      if (m1[i]) lz = MW - 2 - i;
    end
    m2  = m1 << lz;
    e2  = e1 - XW'(lz);
    up  = m2[2] & (m2[1] | m2[0] | m2[3]);
    sum = {1'b0, m2[MAN_W+2:3]} + (MAN_W+1)'(up);
    e3  = e2 + $signed({{(XW-1){1'b0}}, sum[MAN_W]});
    if (!m2[MW-2]) begin
      res = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (e3 >= EMAX_S) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_OVF] = 1'b1;
    end else if (e3 <= ZERO_S) begin
      res = {sign, {(EXP_W+MAN_W){1'b0}}};
      flg[FLG_UNF] = 1'b1;
    end else begin
      res = {sign, e3[EXP_W-1:0], sum[MAN_W-1:0]};
    end
  end
endmodule

// File: rtl/fpu_multicycle.sv
// rtl/fpu_multicycle.sv - handshaked ADD/SUB/MUL/DIV unit with an iterative restoring divider
module fpu_multicycle
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fpu_multicycle_if.slave  bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int MW  = MAN_W + 5;
  localparam int XW  = EXP_W + 3;
  localparam int NIT = MAN_W + 3;
  localparam int CW  = $clog2(NIT);
  localparam logic [EXP_W-1:0]    EMAX    = '1;
  localparam logic [W-1:0]        QNAN    = W'(fpu_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0]        INF_MAG = (W-1)'(fpu_inf(EXP_W, MAN_W));
  localparam logic signed [XW-1:0] BIAS_S = XW'(fpu_bias(EXP_W));

  fpu_state_t      state;
  logic [W-1:0]    a_r, b_r, result_r;
  logic [1:0]      op_r;
  logic [3:0]      flags_r;
  logic            in_ready_r, out_valid_r;
  logic [M:0]      rem, rem_sub;
  logic            rem_ge;
  logic [NIT-1:0]  quo;
  logic [CW-1:0]   cnt;

  logic            sa, sb, sbe, sx, sy, a_ge;
  logic [EXP_W-1:0] ea, eb, ex, ey;
  logic [MAN_W-1:0] fa, fb;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_div_normal;
  logic [M-1:0]    ma, mb, mx, my;
  logic [2*M-1:0]  prod;
  logic [31:0]     d;
  logic [MW-1:0]   xs, ys, ys_sh, mag_add;
  logic            spec;
  logic [W-1:0]    spec_res, rp_res;
  logic [3:0]      spec_flg, rp_flg;
  logic            rp_sign;
  logic signed [XW-1:0] rp_exp;
  logic [MW-1:0]   rp_mag;

  assign {sa, ea, fa} = a_r;
  assign {sb, eb, fb} = b_r;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign prod   = (2*M)'(ma) * (2*M)'(mb);
  assign rem_ge  = (rem >= {1'b0, mb});
  assign rem_sub = rem - {1'b0, mb};

  // Normal divides skip EXEC and start iterating straight from the accept edge.
  assign in_div_normal = (bus.a[W-2:MAN_W] != '0) && (bus.a[W-2:MAN_W] != EMAX) &&
                         (bus.b[W-2:MAN_W] != '0) && (bus.b[W-2:MAN_W] != EMAX);

  always_comb begin
    sbe   = sb ^ (op_r == OP_SUB);
    a_ge  = {ea, fa} >= {eb, fb};
    ex    = a_ge ? ea : eb;
    ey    = a_ge ? eb : ea;
    mx    = a_ge ? ma : mb;
    my    = a_ge ? mb : ma;
    sx    = a_ge ? sa : sbe;
    sy    = a_ge ? sbe : sa;
    d     = 32'(ex) - 32'(ey);
    xs    = {1'b0, mx, 3'b000};
    ys    = {1'b0, my, 3'b000};
    if (d >= 32'(NIT)) ys_sh = MW'(1);
    else ys_sh = (ys >> d) | MW'(|(ys & ~({MW{1'b1}} << d)));
    mag_add = (sx == sy) ? xs + ys_sh : xs - ys_sh;

    if (state == S_DIV_NORM) begin
      rp_sign = sa ^ sb;
      rp_exp  = $signed({3'b000, ea}) - $signed({3'b000, eb}) + BIAS_S;
      rp_mag  = {1'b0, quo, |rem};
    end else if (op_r == OP_MUL) begin
      rp_sign = sa ^ sb;
      rp_exp  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - BIAS_S;
      rp_mag  = prod[2*M-1 -: MW] | MW'(|prod[MAN_W-4:0]);
    end else begin
      rp_sign = (mag_add == '0) ? 1'b0 : sx;
      rp_exp  = $signed({3'b000, ex});
      rp_mag  = mag_add;
    end

    spec     = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
      spec_flg[FLG_INV] = 1'b1;
    end else if (!op_r[1]) begin
      if (a_inf && b_inf && (sa != sbe)) begin
        spec_res = QNAN;
        spec_flg[FLG_INV] = 1'b1;
      end else if (a_inf)           spec_res = {sa, INF_MAG};
      else if (b_inf)               spec_res = {sbe, INF_MAG};
      else if (a_zero && b_zero)    spec_res = {sa & sbe, {(W-1){1'b0}}};
      else if (a_zero)              spec_res = {sbe, eb, fb};
      else if (b_zero)              spec_res = a_r;
      else                          spec = 1'b0;
    end else if (op_r == OP_MUL) begin
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin
        spec_res = QNAN;
        spec_flg[FLG_INV] = 1'b1;
      end else if (a_inf || b_inf)  spec_res = {sa ^ sb, INF_MAG};
      else if (a_zero || b_zero)    spec_res = {sa ^ sb, {(W-1){1'b0}}};
      else                          spec = 1'b0;
    end else begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_res = QNAN;
        spec_flg[FLG_INV] = 1'b1;
      end else if (a_inf)           spec_res = {sa ^ sb, INF_MAG};
      else if (b_zero) begin
        spec_res = {sa ^ sb, INF_MAG};
        spec_flg[FLG_DZ] = 1'b1;
      end else if (b_inf || a_zero) spec_res = {sa ^ sb, {(W-1){1'b0}}};
      else                          spec = 1'b0;
    end
  end

  fpu_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (rp_sign),
    .exp_in (rp_exp),
    .mag    (rp_mag),
    .res    (rp_res),
    .flg    (rp_flg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      flags_r     <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_r        <= bus.a;
          b_r        <= bus.b;
          op_r       <= bus.opcode;
          rem        <= {2'b01, bus.a[MAN_W-1:0]};
          quo        <= '0;
          cnt        <= '0;
          in_ready_r <= 1'b0;
          state      <= (bus.opcode == OP_DIV && in_div_normal) ? S_DIV_ITER : S_EXEC;
        end
        S_EXEC: begin
          result_r    <= spec ? spec_res : rp_res;
          flags_r     <= spec ? spec_flg : rp_flg;
          out_valid_r <= 1'b1;
          state       <= S_DONE;
        end
        S_DIV_ITER: begin
          rem <= rem_ge ? (rem_sub << 1) : (rem << 1);
          quo <= {quo[NIT-2:0], rem_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NIT - 1)) state <= S_DIV_NORM;
        end
        S_DIV_NORM: begin
          result_r    <= rp_res;
          flags_r     <= rp_flg;
          out_valid_r <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
endmodule

// File: tb/tb_fpu_multicycle.sv
// tb/tb_fpu_multicycle.sv - vector table plus hand sequences with an expected-result queue
module tb_fpu_multicycle;
  import fpu_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_multicycle_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fpu_multicycle #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t vecs[16];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.opcode   = v.op;
    bus.a        = v.a;
    bus.b        = v.b;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.opcode   = 2'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic collect(input string tag);
    int   lat;
    vec_t e;
    wait_result(lat);
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", tag, lat);
    end else if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_unexpected: output with empty expected queue", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(bus.result), 64'(e.res));
      check({tag, "_flags"}, 64'(bus.flags), 64'(e.flg));
      check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    end
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "_out_valid_after_hs"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_in_ready_after_hs"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int   lat;
    int   seen;
    vec_t e;

    vecs[0]  = '{OP_ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'h0, 2};
    vecs[1]  = '{OP_MUL, 32'h40400000, 32'hBF000000, 32'hBFC00000, 4'h0, 2};
    vecs[2]  = '{OP_SUB, 32'h40400000, 32'h40400000, 32'h00000000, 4'h0, 2};
    vecs[3]  = '{OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 28};
    vecs[4]  = '{OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'h4, 2};
    vecs[5]  = '{OP_MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h8, 2};
    vecs[6]  = '{OP_MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h2, 2};
    vecs[7]  = '{OP_ADD, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8, 2};
    vecs[8]  = '{OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8, 2};
    vecs[9]  = '{OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 28};
    vecs[10] = '{OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'h1, 2};
    vecs[11] = '{OP_ADD, 32'h3F800000, 32'h00000001, 32'h3F800000, 4'h0, 2};
    vecs[12] = '{OP_DIV, 32'h3F800000, 32'h7F800000, 32'h00000000, 4'h0, 2};
    vecs[13] = '{OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h0, 2};
    vecs[14] = '{OP_ADD, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'h0, 2};
    vecs[15] = '{OP_SUB, 32'h3F800000, 32'h3F400000, 32'h3E800000, 4'h0, 2};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    check("reset_flags", 64'(bus.flags), 64'(0));

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i]);
      collect($sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready is low; new requests are ignored.
    issue('{OP_MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h2, 2});
    wait_result(lat);
    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    e = exp_q.pop_front();
    bus.in_valid = 1'b1;
    bus.opcode   = OP_ADD;
    bus.a        = 32'h3F800000;
    bus.b        = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_result_%0d", i), 64'(bus.result), 64'(e.res));
      check($sformatf("bp_flags_%0d", i), 64'(bus.flags), 64'(e.flg));
      check($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready), 64'(0));
      check($sformatf("bp_valid_%0d", i), 64'(bus.out_valid), 64'(1));
      @(posedge clk);
      @(negedge clk);
    end
    handshake("bp");
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("bp_no_extra_result", 64'(seen), 64'(0));

    // Reset in the middle of the divide iterations discards the operation.
    issue('{OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 28});
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_div_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_div_out_valid", 64'(bus.out_valid), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_div_never_valid", 64'(seen), 64'(0));
    issue(vecs[0]);
    collect("post_rst_add");
    handshake("post_rst_add");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
